// File: rtl/fetch_unit.sv
// fetch_unit: memory-access front end; serves the per-thread register window locally
// and forwards all other addresses to the W_* system bus.
module fetch_unit #(
    parameter int          THREADS  = 4,
    parameter int          NREGS    = 16,
    parameter logic [31:0] REG_BASE = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_enable,
    input  logic        write_mode,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    input  logic [1:0]  thread,
    output logic [31:0] data_o,
    output logic        ack,
    input  logic        W_CLK,
    input  logic        W_ACK,
    input  logic [31:0] W_DATA_I,
    output logic [31:0] W_DATA_O,
    output logic [31:0] W_ADDR,
    output logic        W_WRITE,
    output logic        W_STB
);
    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_regs [THREADS][NREGS];
    logic        w_is_reg, w_reg_req, w_bus_req, w_bus_done;
    logic        w_unused;

    // The bus is sampled on clk, so its own clock reference is not needed.
    assign w_unused = W_CLK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && w_bus_req) w_next = S_BUS;
        if (w_bus_done)                     w_next = S_IDLE;
    end

    always_comb begin
        w_is_reg   = addr[31:4] == REG_BASE[31:4];
        w_reg_req  = r_state == S_IDLE && f_enable && w_is_reg;
        w_bus_req  = r_state == S_IDLE && f_enable && !w_is_reg;
        w_bus_done = r_state == S_BUS && W_ACK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < THREADS; t++)
                for (int r = 0; r < NREGS; r++)
                    r_regs[t][r] <= '0;
        end else if (w_reg_req && write_mode) begin
            r_regs[thread][addr[3:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack      <= 1'b0;
            data_o   <= '0;
            W_STB    <= 1'b0;
            W_WRITE  <= 1'b0;
            W_ADDR   <= '0;
            W_DATA_O <= '0;
        end else begin
            ack <= w_reg_req || w_bus_done;
            if (w_reg_req && !write_mode) data_o <= r_regs[thread][addr[3:0]];
            if (w_bus_req) begin
                W_STB    <= 1'b1;
                W_ADDR   <= addr;
                W_DATA_O <= data_i;
                W_WRITE  <= write_mode;
            end
            // W_WRITE still holds the captured direction until this edge.
            if (w_bus_done) begin
                W_STB   <= 1'b0;
                W_WRITE <= 1'b0;
                if (!W_WRITE) data_o <= W_DATA_I;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_enable = 1'b0;
    logic        write_mode = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_i = '0;
    logic [1:0]  thread = '0;
    logic [31:0] data_o;
    logic        ack;
    logic        W_CLK = 1'b0;
    logic        W_ACK = 1'b0;
    logic [31:0] W_DATA_I = '0;
    logic [31:0] W_DATA_O;
    logic [31:0] W_ADDR;
    logic        W_WRITE;
    logic        W_STB;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .f_enable(f_enable), .write_mode(write_mode),
        .addr(addr), .data_i(data_i), .thread(thread), .data_o(data_o), .ack(ack),
        .W_CLK(W_CLK), .W_ACK(W_ACK), .W_DATA_I(W_DATA_I), .W_DATA_O(W_DATA_O),
        .W_ADDR(W_ADDR), .W_WRITE(W_WRITE), .W_STB(W_STB)
    );

    always #5 clk = ~clk;
    always #7 W_CLK = ~W_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wr, input logic [1:0] th, input logic [31:0] a, input logic [31:0] d);
        f_enable   = 1'b1;
        write_mode = wr;
        thread     = th;
        addr       = a;
        data_i     = d;
    endtask

    initial begin
        #12;
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_stb", {31'b0, W_STB}, 32'h0);
        chk("rst_waddr", W_ADDR, 32'h0);
        step();
        rst_n = 1'b1;

        req(1'b1, 2'd0, 32'hFFFF_FFF0, 32'h1111_1111);
        step(); chk("w1_ack", {31'b0, ack}, 32'h1);
        f_enable = 1'b0;
        step(); chk("w1_idle", {31'b0, ack}, 32'h0);

        req(1'b1, 2'd0, 32'hFFFF_FFF1, 32'h2222_1111);
        step(); chk("wb0_ack", {31'b0, ack}, 32'h1);
        req(1'b1, 2'd1, 32'hFFFF_FFF0, 32'h1112_2222);
        step(); chk("wb1_ack", {31'b0, ack}, 32'h1);
        req(1'b1, 2'd1, 32'hFFFF_FFF1, 32'h2222_2222);
        step(); chk("wb2_ack", {31'b0, ack}, 32'h1);
        chk("wr_keeps_data", data_o, 32'h0);
        f_enable = 1'b0;
        step(); chk("wb_idle", {31'b0, ack}, 32'h0);

        req(1'b0, 2'd0, 32'hFFFF_FFF0, 32'h0);
        step(); chk("rd_t0r0", data_o, 32'h1111_1111); chk("rd_t0r0_ack", {31'b0, ack}, 32'h1);
        req(1'b0, 2'd1, 32'hFFFF_FFF1, 32'h0);
        step(); chk("rd_t1r1", data_o, 32'h2222_2222); chk("rd_t1r1_ack", {31'b0, ack}, 32'h1);
        req(1'b0, 2'd0, 32'hFFFF_FFF1, 32'h0);
        step(); chk("rd_t0r1", data_o, 32'h2222_1111);
        req(1'b0, 2'd1, 32'hFFFF_FFF0, 32'h0);
        step(); chk("rd_t1r0", data_o, 32'h1112_2222);
        req(1'b1, 2'd2, 32'hFFFF_FFF5, 32'hA5A5_5A5A);
        step(); chk("w_t2r5_ack", {31'b0, ack}, 32'h1);
        req(1'b0, 2'd2, 32'hFFFF_FFF5, 32'h0);
        step(); chk("fwd_t2r5", data_o, 32'hA5A5_5A5A);
        req(1'b0, 2'd3, 32'hFFFF_FFF5, 32'h0);
        step(); chk("rd_t3r5", data_o, 32'h0);
        req(1'b0, 2'd3, 32'hFFFF_FFFF, 32'h0);
        step(); chk("rd_t3r15", data_o, 32'h0);
        f_enable = 1'b0;
        step(); chk("rd_idle", {31'b0, ack}, 32'h0); chk("rd_hold", data_o, 32'h0);

        req(1'b0, 2'd0, 32'h0000_1000, 32'h0);
        step();
        chk("br_stb", {31'b0, W_STB}, 32'h1);
        chk("br_addr", W_ADDR, 32'h0000_1000);
        chk("br_write", {31'b0, W_WRITE}, 32'h0);
        chk("br_noack", {31'b0, ack}, 32'h0);
        addr = 32'hFFFF_FFF0;
        write_mode = 1'b1;
        step(); chk("br_hold_addr", W_ADDR, 32'h0000_1000); chk("br_wait_ack", {31'b0, ack}, 32'h0);
        chk("br_no_regwr", {31'b0, W_WRITE}, 32'h0);
        step(); chk("br_wait2", {31'b0, ack}, 32'h0);
        W_ACK = 1'b1; W_DATA_I = 32'hDEAD_BEEF; f_enable = 1'b0;
        step();
        chk("br_ack", {31'b0, ack}, 32'h1);
        chk("br_data", data_o, 32'hDEAD_BEEF);
        chk("br_stb_off", {31'b0, W_STB}, 32'h0);
        W_ACK = 1'b0;
        step(); chk("br_ack_drop", {31'b0, ack}, 32'h0);
        req(1'b0, 2'd0, 32'hFFFF_FFF0, 32'h0);
        step(); chk("reg_unchanged", data_o, 32'h1111_1111);

        req(1'b1, 2'd0, 32'h0000_2000, 32'hCAFE_0001);
        step();
        chk("bw_write", {31'b0, W_WRITE}, 32'h1);
        chk("bw_data", W_DATA_O, 32'hCAFE_0001);
        chk("bw_stb", {31'b0, W_STB}, 32'h1);
        data_i = 32'h0BAD_0BAD;
        step(); chk("bw_hold", W_DATA_O, 32'hCAFE_0001);
        W_ACK = 1'b1; W_DATA_I = 32'h1234_5678; f_enable = 1'b0;
        step();
        chk("bw_ack", {31'b0, ack}, 32'h1);
        chk("bw_data_o", data_o, 32'h1111_1111);
        chk("bw_stb_off", {31'b0, W_STB}, 32'h0);
        chk("bw_write_off", {31'b0, W_WRITE}, 32'h0);
        W_ACK = 1'b0;

        req(1'b0, 2'd0, 32'h0000_4000, 32'h0);
        step(); chk("rb_stb", {31'b0, W_STB}, 32'h1);
        f_enable = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_stb", {31'b0, W_STB}, 32'h0);
        chk("rst_async_ack", {31'b0, ack}, 32'h0);
        chk("rst_async_data", data_o, 32'h0);
        W_ACK = 1'b1;
        step(); chk("rst_no_ack", {31'b0, ack}, 32'h0);
        W_ACK = 1'b0;
        rst_n = 1'b1;
        req(1'b0, 2'd0, 32'hFFFF_FFF0, 32'h0);
        step(); chk("post_rst_rd", data_o, 32'h0); chk("post_rst_ack", {31'b0, ack}, 32'h1);
        chk("post_rst_stb", {31'b0, W_STB}, 32'h0);
        f_enable = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
